pipe_hold_ctrl: RTL and testbench

//  Parametrised pipeline hold/flush controller; successor to the single-cycle jump/hold arbiter.

---
 rtl/pipe_hold_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
//
// Pipeline hold/flush controller sitting between ex/rib/clint/jtag and
// pc_reg/if_id/id_ex. It merges several hold requests, each with its own
// programmable hold depth, into a single hold level. It stretches every jump
// into a multi-cycle Hold_Id flush. It runs a debug-halt FSM that drains the
// bus before it reports halted, and it counts stall cycles.
//
// Hold levels: 0 None, 1 Pc, 2 If, 3 Id (higher value freezes more stages).
//
// Ports
//   clk           in   1           rising-edge clock
//   rst           in   1           asynchronous reset, active low
//   jump_flag_i   in   1           jump request from ex
//   jump_addr_i   in   ADDR_WIDTH  jump target
//   hold_req_i    in   NUM_SRC     per-source hold request (level)
//   bus_idle_i    in   1           no outstanding bus transaction
//   dbg_halt_i    in   1           debug halt request (level)
//   dbg_resume_i  in   1           debug resume pulse
//   cnt_clr_i     in   1           synchronous clear of the stall counter
//   hold_flag_o   out  3           merged hold level
//   jump_flag_o   out  1           jump to pc_reg (combinational pass-through)
//   jump_addr_o   out  ADDR_WIDTH  jump target to pc_reg
//   dbg_halted_o  out  1           core halted and bus drained
//   stall_cnt_o   out  CNT_WIDTH   saturating count of held, non-halted cycles
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
    parameter int                   ADDR_WIDTH   = 32,
    parameter int                   NUM_SRC      = 4,
    parameter logic [3*NUM_SRC-1:0] SRC_LEVEL    = 12'h6D9,
    parameter int                   FLUSH_CYCLES = 1,
    parameter int                   CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [NUM_SRC-1:0]    hold_req_i,
    input  logic                  bus_idle_i,
    input  logic                  dbg_halt_i,
    input  logic                  dbg_resume_i,
    input  logic                  cnt_clr_i,
    output logic [2:0]            hold_flag_o,
    output logic                  jump_flag_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  dbg_halted_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam int            FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic [2:0] max_lvl(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

    // Counter saturates at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic [FC_W-1:0]       flush_cnt;
    logic                  flush_act;
    logic [2:0]            src_lvl;
    logic [2:0]            fsm_lvl;
    logic [2:0]            hold_merged;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    // A jump restarts the flush window rather than extending it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (jump_flag_i) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    assign flush_act = jump_flag_i | (flush_cnt != '0);

    always_comb begin
        src_lvl = HOLD_NONE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hold_req_i[i]) begin
                src_lvl = max_lvl(src_lvl, SRC_LEVEL[3*i +: 3]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Jumps never change the debug state; they only contribute a flush.
    always_comb begin
        state_nxt = state;
        fsm_lvl   = HOLD_NONE;
        case (state)
            ST_RUN: begin
                if (dbg_halt_i) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                fsm_lvl = HOLD_PC;
                if (!dbg_halt_i) begin
                    state_nxt = ST_RUN;
                end else if (bus_idle_i && !(|hold_req_i) && !flush_act) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                fsm_lvl = HOLD_ID;
                if (dbg_resume_i && !dbg_halt_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign hold_merged = max_lvl(max_lvl(flush_act ? HOLD_ID : HOLD_NONE, src_lvl), fsm_lvl);

    // Combinational outputs are gated so that everything reads 0 during reset.
    assign hold_flag_o  = rst ? hold_merged : HOLD_NONE;
    assign jump_flag_o  = rst & jump_flag_i;
    assign jump_addr_o  = rst ? jump_addr_i : '0;
    assign dbg_halted_o = (state == ST_HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt <= '0;
        end else if ((hold_flag_o != HOLD_NONE) && (state != ST_HALTED)) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;

    localparam int AW    = 32;
    localparam int NS    = 4;
    localparam int FLUSH = 3;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          clk;
    logic          rst;
    logic          jump_flag_i;
    logic [AW-1:0] jump_addr_i;
    logic [NS-1:0] hold_req_i;
    logic          bus_idle_i;
    logic          dbg_halt_i;
    logic          dbg_resume_i;
    logic          cnt_clr_i;
    logic [2:0]    hold_flag_o;
    logic          jump_flag_o;
    logic [AW-1:0] jump_addr_o;
    logic          dbg_halted_o;
    logic [CW-1:0] stall_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    pipe_hold_ctrl #(
        .ADDR_WIDTH  (AW),
        .NUM_SRC     (NS),
        .SRC_LEVEL   (12'h6D9),
        .FLUSH_CYCLES(FLUSH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .hold_req_i  (hold_req_i),
        .bus_idle_i  (bus_idle_i),
        .dbg_halt_i  (dbg_halt_i),
        .dbg_resume_i(dbg_resume_i),
        .cnt_clr_i   (cnt_clr_i),
        .hold_flag_o (hold_flag_o),
        .jump_flag_o (jump_flag_o),
        .jump_addr_o (jump_addr_o),
        .dbg_halted_o(dbg_halted_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Hold level per source for SRC_LEVEL = 12'h6D9.
    int lvl_tab [NS] = '{1, 3, 3, 3};
    int m_cyc       = 0;      // cycles since reset release
    int m_last_jump = -1000;  // cycle index of most recent jump
    int m_mode      = 0;      // 0 run, 1 draining, 2 halted
    int m_cnt       = 0;

    function automatic int exp_src();
        int lv = 0;
        for (int i = 0; i < NS; i++)
            if (hold_req_i[i] && lvl_tab[i] > lv) lv = lvl_tab[i];
        return lv;
    endfunction

    // Flush lasts FLUSH cycles counting the jump cycle; a later jump restarts it.
    function automatic bit exp_flush();
        return jump_flag_i || ((m_cyc - m_last_jump) < FLUSH);
    endfunction

    function automatic int exp_hold();
        int h = 0;
        if (!rst) return 0;
        if (exp_flush()) h = 3;
        if (exp_src() > h) h = exp_src();
        if (m_mode == 1 && h < 1) h = 1;
        if (m_mode == 2) h = 3;
        return h;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc       = 0;
            m_last_jump = -1000;
            m_mode      = 0;
            m_cnt       = 0;
        end else begin
            bit fl;
            int h;
            fl = exp_flush();
            h  = exp_hold();
            if (cnt_clr_i) m_cnt = 0;
            else if (h != 0 && m_mode != 2) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            if (m_mode == 0) begin
                if (dbg_halt_i) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!dbg_halt_i) m_mode = 0;
                else if (bus_idle_i && hold_req_i == '0 && !fl) m_mode = 2;
            end else begin
                if (dbg_resume_i && !dbg_halt_i) m_mode = 0;
            end
            if (jump_flag_i) m_last_jump = m_cyc;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        check("m_hold",   64'(hold_flag_o),  64'(exp_hold()));
        check("m_jflag",  64'(jump_flag_o),  64'(rst && jump_flag_i));
        check("m_jaddr",  64'(jump_addr_o),  rst ? 64'(jump_addr_i) : 64'd0);
        check("m_halted", 64'(dbg_halted_o), 64'(rst && m_mode == 2));
        check("m_cnt",    64'(stall_cnt_o),  64'(m_cnt));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; hold_req_i = '0;
        bus_idle_i = 1'b0; dbg_halt_i = 1'b0; dbg_resume_i = 1'b0; cnt_clr_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_hold", 64'(hold_flag_o), 64'd0);
        check("rst_halted", 64'(dbg_halted_o), 64'd0);
        check("rst_cnt", 64'(stall_cnt_o), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // single jump: Id for three cycles, jump_flag_o only in the jump cycle
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_1234;
        @(negedge clk);
        check("j1_hold_t", 64'(hold_flag_o), 64'd3);
        check("j1_jflag_t", 64'(jump_flag_o), 64'd1);
        check("j1_jaddr_t", 64'(jump_addr_o), 64'h1234);
        tick(); jump_flag_i = 1'b0;
        @(negedge clk);
        check("j1_hold_t1", 64'(hold_flag_o), 64'd3);
        check("j1_jflag_t1", 64'(jump_flag_o), 64'd0);
        tick();
        @(negedge clk);
        check("j1_hold_t2", 64'(hold_flag_o), 64'd3);
        tick();
        @(negedge clk);
        check("j1_hold_t3", 64'(hold_flag_o), 64'd0);
        check("j1_cnt", 64'(stall_cnt_o), 64'd3);

        // source levels
        tick(); hold_req_i = 4'b0011;
        @(negedge clk);
        check("src_0011", 64'(hold_flag_o), 64'd3);
        tick(); hold_req_i = 4'b0001;
        @(negedge clk);
        check("src_0001", 64'(hold_flag_o), 64'd1);
        tick(); hold_req_i = 4'b0000;
        @(negedge clk);
        check("src_none", 64'(hold_flag_o), 64'd0);

        // back-to-back jumps restart the flush window
        tick(); jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0040;
        tick(); jump_addr_i = 32'h0000_0080;
        tick(); jump_flag_i = 1'b0;
        @(negedge clk);
        check("j2_hold_t2", 64'(hold_flag_o), 64'd3);
        tick();
        @(negedge clk);
        check("j2_hold_t3", 64'(hold_flag_o), 64'd3);
        tick();
        @(negedge clk);
        check("j2_hold_t4", 64'(hold_flag_o), 64'd0);

        tick(); cnt_clr_i = 1'b1;
        tick(); cnt_clr_i = 1'b0;
        @(negedge clk);
        check("clr_cnt", 64'(stall_cnt_o), 64'd0);

        // debug halt with a busy bus, then drain, halt, resume
        tick(); dbg_halt_i = 1'b1; bus_idle_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("drain_hold", 64'(hold_flag_o), 64'd1);
            check("drain_halted", 64'(dbg_halted_o), 64'd0);
        end
        tick(); bus_idle_i = 1'b1;
        tick();
        @(negedge clk);
        check("halted", 64'(dbg_halted_o), 64'd1);
        check("halted_hold", 64'(hold_flag_o), 64'd3);
        tick(); jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0200;
        @(negedge clk);
        check("halt_jflag", 64'(jump_flag_o), 64'd1);
        tick(); jump_flag_i = 1'b0; dbg_resume_i = 1'b1;
        tick(); dbg_resume_i = 1'b0;
        @(negedge clk);
        check("resume_ignored", 64'(dbg_halted_o), 64'd1);
        tick(); dbg_halt_i = 1'b0;
        tick();
        @(negedge clk);
        check("wait_resume", 64'(dbg_halted_o), 64'd1);
        dbg_resume_i = 1'b1;
        tick(); dbg_resume_i = 1'b0;
        @(negedge clk);
        check("resumed", 64'(dbg_halted_o), 64'd0);
        check("resumed_hold", 64'(hold_flag_o), 64'd0);

        // saturation of the stall counter
        tick(); cnt_clr_i = 1'b1;
        tick(); cnt_clr_i = 1'b0; hold_req_i = 4'b0001;
        repeat (20) tick();
        @(negedge clk);
        check("cnt_sat", 64'(stall_cnt_o), 64'd15);
        tick(); cnt_clr_i = 1'b1;
        tick(); cnt_clr_i = 1'b0;
        @(negedge clk);
        check("cnt_clr_held", 64'(stall_cnt_o), 64'd0);
        tick();
        @(negedge clk);
        check("cnt_after_clr", 64'(stall_cnt_o), 64'd1);

        // asynchronous reset while draining
        tick(); hold_req_i = '0; dbg_halt_i = 1'b1; bus_idle_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("pre_rst_drain", 64'(hold_flag_o), 64'd1);
        #2; rst = 1'b0; jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0300;
        #1;
        check("rst_drain_hold", 64'(hold_flag_o), 64'd0);
        check("rst_drain_jflag", 64'(jump_flag_o), 64'd0);
        check("rst_drain_jaddr", 64'(jump_addr_o), 64'd0);
        check("rst_drain_cnt", 64'(stall_cnt_o), 64'd0);
        tick(); dbg_halt_i = 1'b0; jump_flag_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("post_rst_hold", 64'(hold_flag_o), 64'd0);

        // asynchronous reset mid-flush clears the flush counter
        tick(); jump_flag_i = 1'b1;
        tick(); jump_flag_i = 1'b0;
        @(negedge clk);
        check("pre_rst_flush", 64'(hold_flag_o), 64'd3);
        #2; rst = 1'b0;
        #1;
        check("rst_flush_hold", 64'(hold_flag_o), 64'd0);
        tick(); rst = 1'b1;
        @(negedge clk);
        check("post_rst_flush", 64'(hold_flag_o), 64'd0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
